spart_tx: RTL and testbench
===========================

SPART_TX -- requirements
Module: spart_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter DIV, default 434, clk cycles per serial bit; at least 2.
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port send, input, 1, one-cycle write strobe from the processor send path.
REQ-006 SHALL have port send_data, input, 8, byte written when send=1.
REQ-007 SHALL have port txd, output, 1, serial line, idle high.
REQ-008 SHALL have port full, output, 1, FIFO holds DEPTH bytes.
REQ-009 SHALL have port empty, output, 1, FIFO holds 0 bytes.
REQ-010 SHALL have port busy, output, 1, frame in progress (FSM not IDLE).
REQ-011 SHALL have port overflow, output, 1, sticky: a byte was dropped.

Function
REQ-012 SHALL accept send_data into the FIFO tail at a clk edge with send=1 when count<DEPTH, or when count=DEPTH and a pop occurs the same cycle.
REQ-013 SHALL drop a byte offered while full with no same-cycle pop, set overflow to 1, and leave FIFO contents unchanged.
REQ-014 SHALL keep read/write pointers log2(DEPTH) bits wide, wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide; full=(count==DEPTH), empty=(count==0), both registered-state derived.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-025).
REQ-016 In IDLE with empty=0, SHALL pop the head byte into an 8-bit shift register and enter START at the next edge; txd=1 in IDLE.
REQ-017 SHALL hold each bit on txd for exactly DIV cycles, timed by a bit counter that reloads on every state entry.
REQ-018 START SHALL drive txd=0; DATA SHALL drive bits LSB first, 8 bits counted by a 3-bit index; STOP SHALL drive txd=1; STOP end SHALL return to IDLE.
REQ-019 Frame-to-frame spacing with FIFO non-empty SHALL be 10*DIV+1 cycles (one IDLE cycle).
REQ-020 First-byte latency: send accepted at edge N into an empty idle block SHALL make txd=0 from edge N+2.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged and preserve byte order.
REQ-022 txd SHALL be driven from a flop (glitch-free).

Reset
REQ-023 On rst=1 at an edge: txd=1, busy=0, empty=1, full=0, overflow=0, pointers/count=0, FSM=IDLE, bit counter=0.
REQ-024 Reset mid-frame SHALL abort the frame; txd=1 from the reset edge; buffered bytes are discarded; overflow is cleared only by reset.

Configuration
REQ-025 With macro SPART_TX_PARITY_EN defined, SHALL insert state PARITY between DATA and STOP driving even parity (XOR of 8 data bits) for DIV cycles; frame spacing becomes 11*DIV+1.
REQ-026 Without SPART_TX_PARITY_EN, PARITY state and logic SHALL be absent; frame is 8N1 per REQ-018.

Verification (DIV=4, DEPTH=8 unless stated)
REQ-027 Single send 0xA5 from reset -> txd bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, start bit at edge N+2; busy high 40 cycles.
REQ-028 10 sends on consecutive cycles from reset -> byte 9 dropped, full=1 and overflow=1 after edge 10; bytes 0..8 transmitted in order; empty=1 after last pop.
REQ-029 Two sends 0x00,0xFF -> second start bit falls exactly 41 cycles after the first.
REQ-030 rst asserted during DATA bit 3 -> txd=1, busy=0, empty=1, overflow=0 the next cycle; following send 0x3C yields a complete correct frame.
REQ-031 SPART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after bit 7, stop bit follows; back-to-back spacing 45 cycles.
REQ-032 FIFO full, send coinciding with IDLE pop -> byte accepted, count stays 8, overflow stays 0.

Source files
------------

// File: rtl/spart_tx.sv
// spart_tx: byte FIFO feeding an 8N1 serial transmitter, DIV clocks per bit.
// Optional build macro SPART_TX_PARITY_EN adds an even-parity bit after the
// data bits (8E1). The default build (macro undefined) has no parity logic.
module spart_tx #(
  parameter int DEPTH = 8,
  parameter int DIV   = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] send_data,
  output logic       txd,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [CW-1:0] r_bitcnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
`ifdef SPART_TX_PARITY_EN
  logic          r_par;
`endif

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  // The transmitter only takes a byte while idle; a pop frees a slot, so a
  // write into a full FIFO in that same cycle still lands.
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign w_push  = send && (!w_full || w_pop);

  assign full     = w_full;
  assign empty    = w_empty;
  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;
  assign txd      = r_txd;

  // FIFO storage; contents need no reset since count gates all reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= send_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (send && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Frame sequencer: each state lasts DIV cycles via a reloading down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
`ifdef SPART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_idx    <= '0;
            r_bitcnt <= BIT_LAST;
            r_state  <= START;
`ifdef SPART_TX_PARITY_EN
            r_par    <= ^r_mem[r_rptr];
`endif
          end
        end
        START: begin
          if (r_bitcnt == '0) begin
            r_bitcnt <= BIT_LAST;
            r_state  <= DATA;
          end else begin
            r_bitcnt <= r_bitcnt - 1'b1;
          end
        end
        DATA: begin
          if (r_bitcnt == '0) begin
            r_bitcnt <= BIT_LAST;
            if (r_idx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_bitcnt <= r_bitcnt - 1'b1;
          end
        end
`ifdef SPART_TX_PARITY_EN
        PARITY: begin
          if (r_bitcnt == '0) begin
            r_bitcnt <= BIT_LAST;
            r_state  <= STOP;
          end else begin
            r_bitcnt <= r_bitcnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_bitcnt == '0) begin
            r_bitcnt <= BIT_LAST;
            r_state  <= IDLE;
          end else begin
            r_bitcnt <= r_bitcnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line driver: registered copy of the current state's bit, so txd trails
  // the state by one cycle and never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd <= 1'b1;
    end else begin
      case (r_state)
        IDLE:    r_txd <= 1'b1;
        START:   r_txd <= 1'b0;
        DATA:    r_txd <= r_shift[0];
`ifdef SPART_TX_PARITY_EN
        PARITY:  r_txd <= r_par;
`endif
        STOP:    r_txd <= 1'b1;
        default: r_txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: directed stimulus with a byte scoreboard; a monitor decodes
// every frame on txd cycle by cycle and compares it with the queued byte.
module tb_spart_tx;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;
`ifdef SPART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int NS = FB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       txd, full, empty, busy, overflow;

  spart_tx #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .send(send), .send_data(send_data),
    .txd(txd), .full(full), .empty(empty), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int busy_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] sb[$];
  int starts[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor: a low txd at a negedge marks the first cycle of a start bit
  initial begin : mon
    logic [63:0] smp;
    logic [63:0] expv;
    logic [FB-1:0] eb;
    logic [7:0] b;
    bit ab;
    int k;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        starts.push_back(cyc);
        smp = '0;
        smp[0] = txd;
        ab = 1'b0;
        k = 1;
        while (k < NS && !ab) begin
          @(negedge clk);
          if (rst === 1'b1) ab = 1'b1;
          else smp[k] = txd;
          k++;
        end
        if (!ab) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_frame: got frame %0h expected no frame", smp);
          end else begin
            b = sb.pop_front();
            eb = '0;
            eb[8:1] = b;
`ifdef SPART_TX_PARITY_EN
            eb[9] = ^b;
`endif
            eb[FB-1] = 1'b1;
            expv = '0;
            for (int j = 0; j < NS; j++) expv[j] = eb[j / DIV];
            chk($sformatf("frame_%02h", b), smp, expv);
          end
        end
      end
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst = 1'b1; sb.delete();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin : stim
    int t0, b0, s0, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_txd", 64'(txd), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // single byte: latency, busy length, frame content
    b0 = busy_cnt;
    s0 = starts.size();
    @(posedge clk); #1 send = 1'b1; send_data = 8'hA5; sb.push_back(8'hA5);
    @(posedge clk); #1 t0 = cyc; send = 1'b0;
    drain(200);
    repeat (4) @(negedge clk);
    if (starts.size() > s0) chk("start_latency", 64'(starts[s0] - t0), 64'd2);
    else chk("start_seen", 64'(starts.size()), 64'(s0 + 1));
    chk("busy_cycles", 64'(busy_cnt - b0), 64'(NS));

    // ten back-to-back writes: tenth dropped
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      send = 1'b1;
      send_data = 8'(8'h30 + i);
      if (i < 9) sb.push_back(8'(8'h30 + i));
      @(posedge clk); #1;
    end
    send = 1'b0;
    chk("burst_full", 64'(full), 64'd1);
    chk("burst_ovf", 64'(overflow), 64'd1);
    drain(800);
    chk("burst_empty", 64'(empty), 64'd1);
    chk("burst_ovf_sticky", 64'(overflow), 64'd1);

    // reset during data bit 3 aborts the frame and clears overflow
    @(posedge clk); #1 send = 1'b1; send_data = 8'h5A; sb.push_back(8'h5A);
    @(posedge clk); #1 send = 1'b0;
    repeat (18) @(posedge clk);
    #1 rst = 1'b1; sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_txd", 64'(txd), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_empty", 64'(empty), 64'd1);
    chk("abort_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1 send = 1'b1; send_data = 8'h3C; sb.push_back(8'h3C);
    @(posedge clk); #1 send = 1'b0;
    drain(200);

    // frame-to-frame spacing
    do_reset();
    s0 = starts.size();
    @(posedge clk); #1 send = 1'b1; send_data = 8'h00; sb.push_back(8'h00);
    @(posedge clk); #1 send_data = 8'hFF; sb.push_back(8'hFF);
    @(posedge clk); #1 send = 1'b0;
    drain(300);
    if (starts.size() >= s0 + 2) chk("spacing", 64'(starts[s0+1] - starts[s0]), 64'(NS + 1));
    else chk("spacing_starts", 64'(starts.size()), 64'(s0 + 2));

    // full FIFO, write coinciding with the idle pop
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      send = 1'b1;
      send_data = 8'(8'hC0 + i);
      sb.push_back(8'(8'hC0 + i));
      @(posedge clk); #1;
    end
    send = 1'b0;
    chk("fill_full", 64'(full), 64'd1);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 64'(n < 200), 64'd1);
    send = 1'b1; send_data = 8'h07; sb.push_back(8'h07);
    @(posedge clk); #1 send = 1'b0;
    chk("pop_push_full", 64'(full), 64'd1);
    chk("pop_push_ovf", 64'(overflow), 64'd0);
    drain(900);
    chk("final_empty", 64'(empty), 64'd1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
